bloom_sram_ctrl: RTL and testbench

- Counting-Bloom-filter controller between the TCP tuple parser (bloom_wr/bloom_rdy, index_0/index_1, pkt_is_ack) and one external SRAM port.
- Each accepted request becomes a read-modify-write sequence on two counter words.
- Data segments insert into the filter. ACKs test for a match and remove the entry on a hit.
- Also owns a full-table clear sweep, arbitrated against parser requests.

---
 rtl/bloom_sram_ctrl_pkg.sv | 30 +++
 rtl/bloom_sram_port.sv | 59 +++++
 rtl/bloom_sram_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_bloom_sram_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bloom_sram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// bloom_sram_ctrl_pkg
// Shared definitions for the counting-Bloom-filter SRAM controller:
//   - state_e   : one-hot controller states (9 states)
//   - op_e      : latched request kind (insert / ACK test-and-remove)
//   - COUNT_LSB : bit position of the counter field inside an SRAM word
// ---------------------------------------------------------------------------
package bloom_sram_ctrl_pkg;

  typedef enum logic [8:0] {
    ST_IDLE   = 9'b0_0000_0001,
    ST_RD_A   = 9'b0_0000_0010,
    ST_WAIT_A = 9'b0_0000_0100,
    ST_RD_B   = 9'b0_0000_1000,
    ST_WAIT_B = 9'b0_0001_0000,
    ST_DECIDE = 9'b0_0010_0000,
    ST_WR_A   = 9'b0_0100_0000,
    ST_WR_B   = 9'b0_1000_0000,
    ST_CLEAR  = 9'b1_0000_0000
  } state_e;

  typedef enum logic {
    OP_INSERT = 1'b0,
    OP_ACK    = 1'b1
  } op_e;

  // Counter field occupies word bits [COUNT_LSB +: COUNT_WIDTH].
  localparam int COUNT_LSB = 0;

endpackage

// File: rtl/bloom_sram_port.sv
// ---------------------------------------------------------------------------
// bloom_sram_port
// Single-outstanding SRAM request holder. A start strobe loads the access;
// req/addr/data/direction stay stable until the grant, and done flags the
// grant cycle. A start in the grant cycle launches the next access
// back-to-back.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             load a new access (only when idle or in the grant cycle)
//   rd_wr_L           1 = read, 0 = write for the access being loaded
//   addr, wr_data     address / write data for the access being loaded
//   sram_ack          one-cycle grant from the SRAM
//   sram_req          registered request to the SRAM
//   sram_rd_wr_L      registered direction
//   sram_addr         registered address
//   sram_wr_data      registered write data
//   done              grant of the current access (sram_req && sram_ack)
// ---------------------------------------------------------------------------
module bloom_sram_port
  import bloom_sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 36
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rd_wr_L,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  sram_ack,
  output logic                  sram_req,
  output logic                  sram_rd_wr_L,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wr_data,
  output logic                  done
);

  assign done = sram_req && sram_ack;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      sram_req     <= 1'b0;
      sram_rd_wr_L <= 1'b1;
      sram_addr    <= '0;
      sram_wr_data <= '0;
    end else if (start) begin
      sram_req     <= 1'b1;
      sram_rd_wr_L <= rd_wr_L;
      sram_addr    <= addr;
      sram_wr_data <= wr_data;
    end else if (done) begin
      sram_req <= 1'b0;
    end
  end

endmodule

// File: rtl/bloom_sram_ctrl.sv
// ---------------------------------------------------------------------------
// bloom_sram_ctrl
// Counting-Bloom-filter controller. Each accepted parser request performs a
// read-modify-write on the two counter words addressed by index_0/index_1:
// inserts increment (saturating), ACKs decrement both on a hit and report
// match/miss. A clear_req pulse schedules a sweep writing zero to every word,
// taken only once the controller is idle.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   bloom_wr, bloom_rdy        parser request strobe / ready
//   index_0, index_1           hash indices (word addresses)
//   pkt_is_ack                 1 = ACK test/remove, 0 = insert
//   clear_req, clear_busy      clear pulse / sweep pending or running
//   sram_req .. sram_rd_vld    external SRAM port
//   match_pulse, miss_pulse    one-cycle ACK result strobes
//   num_insert/match/miss      32-bit wrapping statistics
// ---------------------------------------------------------------------------
module bloom_sram_ctrl
  import bloom_sram_ctrl_pkg::*;
#(
  parameter int SRAM_ADDR_WIDTH = 19,
  parameter int SRAM_DATA_WIDTH = 36,
  parameter int COUNT_WIDTH     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       bloom_wr,
  output logic                       bloom_rdy,
  input  logic [SRAM_ADDR_WIDTH-1:0] index_0,
  input  logic [SRAM_ADDR_WIDTH-1:0] index_1,
  input  logic                       pkt_is_ack,
  input  logic                       clear_req,
  output logic                       clear_busy,
  output logic                       sram_req,
  output logic                       sram_rd_wr_L,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [SRAM_DATA_WIDTH-1:0] sram_wr_data,
  input  logic                       sram_ack,
  input  logic [SRAM_DATA_WIDTH-1:0] sram_rd_data,
  input  logic                       sram_rd_vld,
  output logic                       match_pulse,
  output logic                       miss_pulse,
  output logic [31:0]                num_insert,
  output logic [31:0]                num_match,
  output logic [31:0]                num_miss
);

  localparam logic [COUNT_WIDTH-1:0]     CNT_MAX   = '1;
  localparam logic [COUNT_WIDTH-1:0]     CNT_ONE   = 1;
  localparam logic [SRAM_ADDR_WIDTH-1:0] ADDR_LAST = '1;
  localparam logic [SRAM_ADDR_WIDTH-1:0] ADDR_ONE  = 1;

  state_e                     state, state_nxt;
  op_e                        op;
  logic                       clear_pending;
  logic [SRAM_ADDR_WIDTH-1:0] idx_a, idx_b, clear_addr;
  logic [COUNT_WIDTH-1:0]     cnt_a, cnt_b, new_a, new_b, wr_cnt;
  logic                       accept, same_idx, hit, sweep_end;

  logic                       port_start, port_rd, port_done;
  logic [SRAM_ADDR_WIDTH-1:0] port_addr;
  logic [SRAM_DATA_WIDTH-1:0] port_data;

  // Only the counter field of a read word matters; the rest is ignored.
  logic rd_data_unused;
  assign rd_data_unused = ^sram_rd_data;

  // Reset is folded in so the parser never sees ready while reset is held.
  assign bloom_rdy  = !reset && (state == ST_IDLE) && !clear_pending;
  assign accept     = bloom_wr && bloom_rdy;
  assign clear_busy = clear_pending;
  assign same_idx   = (idx_a == idx_b);
  // Equal indices share one word, so only cnt_a is meaningful then.
  assign hit        = (cnt_a != '0) && (same_idx || (cnt_b != '0));
  assign sweep_end  = (state == ST_CLEAR) && port_done && (clear_addr == ADDR_LAST);

  // Decrement is only written back on a hit, so it never wraps.
  always_comb begin
    if (op == OP_INSERT) begin
      new_a = (cnt_a == CNT_MAX) ? cnt_a : cnt_a + CNT_ONE;
      new_b = (cnt_b == CNT_MAX) ? cnt_b : cnt_b + CNT_ONE;
    end else begin
      new_a = cnt_a - CNT_ONE;
      new_b = cnt_b - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no branch can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    port_start = 1'b0;
    port_rd    = 1'b1;
    port_addr  = '0;
    wr_cnt     = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt  = ST_RD_A;
          port_start = 1'b1;
          port_addr  = index_0;
        end else if (clear_pending) begin
          state_nxt  = ST_CLEAR;
          port_start = 1'b1;
          port_rd    = 1'b0;
        end
      end
      ST_RD_A: if (port_done) state_nxt = ST_WAIT_A;
      ST_WAIT_A: begin
        if (sram_rd_vld) begin
          if (same_idx) begin
            state_nxt = ST_DECIDE;
          end else begin
            state_nxt  = ST_RD_B;
            port_start = 1'b1;
            port_addr  = idx_b;
          end
        end
      end
      ST_RD_B:   if (port_done)   state_nxt = ST_WAIT_B;
      ST_WAIT_B: if (sram_rd_vld) state_nxt = ST_DECIDE;
      ST_DECIDE: begin
        if ((op == OP_INSERT) || hit) begin
          state_nxt  = ST_WR_A;
          port_start = 1'b1;
          port_rd    = 1'b0;
          port_addr  = idx_a;
          wr_cnt     = new_a;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WR_A: begin
        if (port_done) begin
          if (same_idx) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt  = ST_WR_B;
            port_start = 1'b1;
            port_rd    = 1'b0;
            port_addr  = idx_b;
            wr_cnt     = new_b;
          end
        end
      end
      ST_WR_B: if (port_done) state_nxt = ST_IDLE;
      ST_CLEAR: begin
        if (port_done) begin
          if (clear_addr == ADDR_LAST) begin
            state_nxt = ST_IDLE;
          end else begin
            port_start = 1'b1;
            port_rd    = 1'b0;
            port_addr  = clear_addr + ADDR_ONE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    port_data = '0;
    port_data[COUNT_LSB +: COUNT_WIDTH] = wr_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clear_pending <= 1'b0;
      clear_addr    <= '0;
      match_pulse   <= 1'b0;
      miss_pulse    <= 1'b0;
      num_insert    <= '0;
      num_match     <= '0;
      num_miss      <= '0;
    end else begin
      match_pulse <= (state == ST_DECIDE) && (op == OP_ACK) && hit;
      miss_pulse  <= (state == ST_DECIDE) && (op == OP_ACK) && !hit;
      if (state == ST_DECIDE) begin
        if (op == OP_INSERT) num_insert <= num_insert + 32'd1;
        else if (hit)        num_match  <= num_match + 32'd1;
        else                 num_miss   <= num_miss + 32'd1;
      end
      // A request arriving while a sweep is already pending is dropped.
      if (clear_req && !clear_pending) clear_pending <= 1'b1;
      else if (sweep_end)              clear_pending <= 1'b0;
      // Wraps back to zero after the last address, ready for the next sweep.
      if ((state == ST_CLEAR) && port_done) clear_addr <= clear_addr + ADDR_ONE;
    end
  end

  // NOTE: operand registers carry no reset; each is written (accept, read
  // return) before any state that consumes it.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_a <= index_0;
      idx_b <= index_1;
      op    <= op_e'(pkt_is_ack);
    end
    if ((state == ST_WAIT_A) && sram_rd_vld) cnt_a <= sram_rd_data[COUNT_LSB +: COUNT_WIDTH];
    if ((state == ST_WAIT_B) && sram_rd_vld) cnt_b <= sram_rd_data[COUNT_LSB +: COUNT_WIDTH];
  end

  bloom_sram_port #(
    .ADDR_WIDTH (SRAM_ADDR_WIDTH),
    .DATA_WIDTH (SRAM_DATA_WIDTH)
  ) u_port (
    .clk          (clk),
    .reset        (reset),
    .start        (port_start),
    .rd_wr_L      (port_rd),
    .addr         (port_addr),
    .wr_data      (port_data),
    .sram_ack     (sram_ack),
    .sram_req     (sram_req),
    .sram_rd_wr_L (sram_rd_wr_L),
    .sram_addr    (sram_addr),
    .sram_wr_data (sram_wr_data),
    .done         (port_done)
  );

endmodule

// File: tb/tb_bloom_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bloom_sram_ctrl
// Two controller instances: a full-size one (19-bit addresses) for the
// read-modify-write scenarios and reset recovery, and a 4-bit-address one
// whose 16-word clear sweep is short enough to observe completely.
// Expected SRAM writes and ACK results are queued when stimulus is issued;
// negedge monitors pop and compare them as the DUTs present them.
// ---------------------------------------------------------------------------
module tb_bloom_sram_ctrl;

  localparam int AW  = 19;
  localparam int DW  = 36;
  localparam int AWC = 4;

  typedef enum logic [1:0] {EV_WRITE, EV_MATCH, EV_MISS} ev_e;
  typedef struct {
    ev_e           kind;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t q[$];
  exp_t q_c[$];
  int   checks = 0;
  int   errors = 0;
  int   rd_count = 0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- full-size instance ----------------
  logic          bloom_wr, bloom_rdy, pkt_is_ack, clear_req, clear_busy;
  logic [AW-1:0] index_0, index_1, sram_addr;
  logic          sram_req, sram_rd_wr_L, sram_rd_vld = 1'b0, sram_ack = 1'b0;
  logic [DW-1:0] sram_wr_data, sram_rd_data = '0;
  logic          match_pulse, miss_pulse;
  logic [31:0]   num_insert, num_match, num_miss;

  bloom_sram_ctrl dut (
    .clk(clk), .reset(reset), .bloom_wr(bloom_wr), .bloom_rdy(bloom_rdy),
    .index_0(index_0), .index_1(index_1), .pkt_is_ack(pkt_is_ack),
    .clear_req(clear_req), .clear_busy(clear_busy),
    .sram_req(sram_req), .sram_rd_wr_L(sram_rd_wr_L), .sram_addr(sram_addr),
    .sram_wr_data(sram_wr_data), .sram_ack(sram_ack), .sram_rd_data(sram_rd_data),
    .sram_rd_vld(sram_rd_vld), .match_pulse(match_pulse), .miss_pulse(miss_pulse),
    .num_insert(num_insert), .num_match(num_match), .num_miss(num_miss)
  );

  // ---------------- 16-word instance ----------------
  logic           bloom_wr_c, bloom_rdy_c, pkt_is_ack_c, clear_req_c, clear_busy_c;
  logic [AWC-1:0] index_0_c, index_1_c, sram_addr_c;
  logic           sram_req_c, sram_rd_wr_L_c, sram_rd_vld_c = 1'b0, sram_ack_c = 1'b0;
  logic [DW-1:0]  sram_wr_data_c, sram_rd_data_c = '0;
  logic           match_pulse_c, miss_pulse_c;
  logic [31:0]    num_insert_c, num_match_c, num_miss_c;

  bloom_sram_ctrl #(.SRAM_ADDR_WIDTH(AWC), .SRAM_DATA_WIDTH(DW), .COUNT_WIDTH(4)) dut_c (
    .clk(clk), .reset(reset), .bloom_wr(bloom_wr_c), .bloom_rdy(bloom_rdy_c),
    .index_0(index_0_c), .index_1(index_1_c), .pkt_is_ack(pkt_is_ack_c),
    .clear_req(clear_req_c), .clear_busy(clear_busy_c),
    .sram_req(sram_req_c), .sram_rd_wr_L(sram_rd_wr_L_c), .sram_addr(sram_addr_c),
    .sram_wr_data(sram_wr_data_c), .sram_ack(sram_ack_c), .sram_rd_data(sram_rd_data_c),
    .sram_rd_vld(sram_rd_vld_c), .match_pulse(match_pulse_c), .miss_pulse(miss_pulse_c),
    .num_insert(num_insert_c), .num_match(num_match_c), .num_miss(num_miss_c)
  );

  // ---------------- SRAM models ----------------
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] mem_c [16];
  int            ack_delay = 0;
  int            vld_delay = 1;
  int            wait_cnt = 0;
  int            rd_left = 0;
  bit            rd_pend = 1'b0;
  logic [DW-1:0] rd_q = '0;
  bit            rd_pend_c = 1'b0;
  logic [DW-1:0] rd_q_c = '0;

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  // Commit the access granted at this edge, then drive ack/rd_vld for the
  // coming cycle once the DUT's registered request has settled.
  always @(posedge clk) begin
    if (sram_req && sram_ack) begin
      if (!sram_rd_wr_L) begin
        mem[sram_addr] = sram_wr_data;
      end else begin
        rd_q    = mem_rd(sram_addr);
        rd_pend = 1'b1;
        rd_left = vld_delay - 1;
      end
    end
    #1;
    sram_rd_vld = 1'b0;
    if (rd_pend) begin
      if (rd_left == 0) begin
        sram_rd_vld  = 1'b1;
        sram_rd_data = rd_q;
        rd_pend      = 1'b0;
      end else begin
        rd_left--;
      end
    end
    if (sram_req) begin
      if (wait_cnt >= ack_delay) begin
        sram_ack = 1'b1;
        wait_cnt = 0;
      end else begin
        sram_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      sram_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  always @(posedge clk) begin
    if (sram_req_c && sram_ack_c) begin
      if (!sram_rd_wr_L_c) begin
        mem_c[sram_addr_c] = sram_wr_data_c;
      end else begin
        rd_q_c    = mem_c[sram_addr_c];
        rd_pend_c = 1'b1;
      end
    end
    #1;
    sram_rd_vld_c  = rd_pend_c;
    sram_rd_data_c = rd_q_c;
    rd_pend_c      = 1'b0;
    sram_ack_c     = sram_req_c;
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic mon_event(input bit use_c, input ev_e kind, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data);
    exp_t e;
    if ((use_c && q_c.size() == 0) || (!use_c && q.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event inst=%0d kind=%0d addr=0x%0h data=0x%0h required=none",
               use_c, kind, addr, data);
      return;
    end
    if (use_c) e = q_c.pop_front();
    else       e = q.pop_front();
    check(use_c ? "c_event_kind" : "event_kind", 64'(kind), 64'(e.kind));
    if (kind == EV_WRITE) begin
      check(use_c ? "c_write_addr" : "write_addr", 64'(addr), 64'(e.addr));
      check(use_c ? "c_write_data" : "write_data", 64'(data), 64'(e.data));
    end
  endtask

  // ACK results are taken before writes; a pulse never follows its own writes.
  always @(negedge clk) begin
    if (match_pulse) mon_event(1'b0, EV_MATCH, '0, '0);
    if (miss_pulse)  mon_event(1'b0, EV_MISS, '0, '0);
    if (sram_req && sram_ack && !sram_rd_wr_L) mon_event(1'b0, EV_WRITE, sram_addr, sram_wr_data);
    if (sram_req && sram_ack && sram_rd_wr_L)  rd_count++;
  end

  always @(negedge clk) begin
    if (match_pulse_c) mon_event(1'b1, EV_MATCH, '0, '0);
    if (miss_pulse_c)  mon_event(1'b1, EV_MISS, '0, '0);
    if (sram_req_c && sram_ack_c && !sram_rd_wr_L_c)
      mon_event(1'b1, EV_WRITE, AW'(sram_addr_c), sram_wr_data_c);
  end

  task automatic exp_push(input bit use_c, input ev_e kind, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    if (use_c) q_c.push_back(e);
    else       q.push_back(e);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic issue_op(input logic [AW-1:0] i0, input logic [AW-1:0] i1, input logic is_ack);
    int n = 0;
    @(negedge clk);
    while (!bloom_rdy && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("rdy_before_issue", bloom_rdy, 1);
    bloom_wr   = 1'b1;
    index_0    = i0;
    index_1    = i1;
    pkt_is_ack = is_ack;
    @(posedge clk);
    #1 bloom_wr = 1'b0;
  endtask

  // Returns the number of cycles bloom_rdy stayed low after the accept.
  task automatic do_op(input logic [AW-1:0] i0, input logic [AW-1:0] i1, input logic is_ack,
                       output int low);
    issue_op(i0, i1, is_ack);
    low = 0;
    @(negedge clk);
    while (!bloom_rdy && low < 500) begin
      low++;
      @(negedge clk);
    end
    check("op_completes", bloom_rdy, 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q.size() != 0 || q_c.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", 64'(q.size() + q_c.size()), 0);
  endtask

  function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] word);
    logic [3:0] c;
    c = word[3:0];
    return (c == 4'hF) ? 36'hF : 36'(c + 4'd1);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int            low;
    int            rd0;
    int            n;
    logic [63:0]   rnd;
    logic [DW-1:0] e3, e9;

    reset = 1'b1;
    bloom_wr = 1'b0; index_0 = '0; index_1 = '0; pkt_is_ack = 1'b0; clear_req = 1'b0;
    bloom_wr_c = 1'b0; index_0_c = '0; index_1_c = '0; pkt_is_ack_c = 1'b0; clear_req_c = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rdy_in_reset", bloom_rdy, 0);
    check("req_in_reset", sram_req, 0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    check("rdy_after_reset", bloom_rdy, 1);
    check("clear_busy_after_reset", clear_busy, 0);
    check("counters_after_reset", {num_insert, num_match}, 0);
    check("pulses_after_reset", {match_pulse, miss_pulse, sram_req}, 0);

    // Insert into zeroed SRAM: two writes of 1, ready low for 7 cycles.
    exp_push(0, EV_WRITE, 19'h00010, 36'd1);
    exp_push(0, EV_WRITE, 19'h00020, 36'd1);
    do_op(19'h00010, 19'h00020, 1'b0, low);
    check("insert_rdy_low_cycles", 64'(low), 7);
    wait_drain();
    check("num_insert_1", num_insert, 1);

    // ACK hit: both counts back to zero.
    exp_push(0, EV_MATCH, '0, '0);
    exp_push(0, EV_WRITE, 19'h00010, 36'd0);
    exp_push(0, EV_WRITE, 19'h00020, 36'd0);
    do_op(19'h00010, 19'h00020, 1'b1, low);
    wait_drain();
    check("num_match_1", num_match, 1);
    check("word_10_zero", mem_rd(19'h00010), 0);

    // Same ACK again: miss, no writes, 5-cycle turnaround.
    exp_push(0, EV_MISS, '0, '0);
    do_op(19'h00010, 19'h00020, 1'b1, low);
    check("miss_rdy_low_cycles", 64'(low), 5);
    wait_drain();
    check("num_miss_1", num_miss, 1);

    // Equal indices: one read, one write, +1 per op.
    rd0 = rd_count;
    exp_push(0, EV_WRITE, 19'h00005, 36'd1);
    do_op(19'h00005, 19'h00005, 1'b0, low);
    check("same_idx_one_read", 64'(rd_count - rd0), 1);
    exp_push(0, EV_WRITE, 19'h00005, 36'd2);
    do_op(19'h00005, 19'h00005, 1'b0, low);
    wait_drain();
    check("same_idx_two_reads", 64'(rd_count - rd0), 2);
    check("word_5_is_2", mem_rd(19'h00005), 2);

    // Saturated counter (upper word bits set) written back as 0xF, upper bits zero.
    mem[19'h00007] = 36'hABCDE000F;
    exp_push(0, EV_WRITE, 19'h00007, 36'h00000000F);
    exp_push(0, EV_WRITE, 19'h00008, 36'd1);
    do_op(19'h00007, 19'h00008, 1'b0, low);
    wait_drain();
    check("num_insert_4", num_insert, 4);

    // ACK with one zero counter is a miss.
    exp_push(0, EV_MISS, '0, '0);
    do_op(19'h00007, 19'h00009, 1'b1, low);
    wait_drain();
    check("num_miss_2", num_miss, 2);

    // Same-index ACK hit: single decrement write.
    exp_push(0, EV_MATCH, '0, '0);
    exp_push(0, EV_WRITE, 19'h00005, 36'd1);
    do_op(19'h00005, 19'h00005, 1'b1, low);
    wait_drain();
    check("num_match_2", num_match, 2);

    // ---- clear sweep on the 16-word instance ----
    for (int i = 0; i < 16; i++) begin
      rnd = {$urandom, $urandom};
      mem_c[i] = rnd[DW-1:0];
    end
    e3 = sat_inc(mem_c[3]);
    e9 = sat_inc(mem_c[9]);
    exp_push(1, EV_WRITE, 19'd3, e3);
    exp_push(1, EV_WRITE, 19'd9, e9);
    @(negedge clk);
    check("c_rdy_idle", bloom_rdy_c, 1);
    bloom_wr_c = 1'b1; index_0_c = 4'd3; index_1_c = 4'd9; pkt_is_ack_c = 1'b0;
    @(posedge clk);
    #1;
    // Held request queued behind the sweep.
    index_0_c = 4'd2; index_1_c = 4'd12;
    @(negedge clk) clear_req_c = 1'b1;
    @(negedge clk) clear_req_c = 1'b0;
    check("c_clear_busy_set", clear_busy_c, 1);
    for (int a = 0; a < 16; a++) exp_push(1, EV_WRITE, AW'(a), 36'd0);
    exp_push(1, EV_WRITE, 19'd2, 36'd1);
    exp_push(1, EV_WRITE, 19'd12, 36'd1);
    n = 0;
    while (!bloom_rdy_c && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("c_held_req_ready", bloom_rdy_c, 1);
    check("c_clear_busy_fell", clear_busy_c, 0);
    check("c_sweep_done_before_accept", 64'(q_c.size()), 2);
    @(posedge clk);
    #1 bloom_wr_c = 1'b0;
    wait_drain();
    check("c_num_insert_2", num_insert_c, 2);
    check("c_word_0_cleared", mem_c[0], 0);

    // ---- reset in WAIT_B with a slow SRAM ----
    ack_delay = 3;
    vld_delay = 5;
    rd0 = rd_count;
    issue_op(19'h00100, 19'h00200, 1'b0);
    n = 0;
    while (rd_count < rd0 + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("two_reads_granted", 64'(rd_count - rd0), 2);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    check("slow_req_in_reset", sram_req, 0);
    check("slow_rdy_in_reset", bloom_rdy, 0);
    repeat (8) @(negedge clk);
    check("slow_rdy_late_reset", {bloom_rdy, sram_req}, 0);
    reset = 1'b0;
    @(negedge clk);
    check("slow_rdy_after_reset", bloom_rdy, 1);
    check("slow_num_insert_reset", num_insert, 0);
    exp_push(0, EV_WRITE, 19'h00300, 36'd1);
    exp_push(0, EV_WRITE, 19'h00301, 36'd1);
    do_op(19'h00300, 19'h00301, 1'b0, low);
    wait_drain();
    check("slow_num_insert_1", num_insert, 1);
    check("abandoned_word_untouched", mem_rd(19'h00100), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
